// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the LC-3 fetch-stage sequencer.
package fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF       = 16;
    localparam int unsigned FLUSH_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        REDIR,
        FLUSH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_exc;
        logic [ADDR_W_DEF-1:0] addr;
    } redirect_t;

endpackage

// File: rtl/fetch_redirect_hold.sv
// One-entry pending redirect register with exception-over-branch priority.
module fetch_redirect_hold
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_br_req,
    input  logic [ADDR_W-1:0] i_br_addr,
    input  logic              i_exc_req,
    input  logic [ADDR_W-1:0] i_exc_vec,
    input  logic              i_consume,
    output logic              o_sel_valid,
    output logic [ADDR_W-1:0] o_sel_addr
);

    logic              r_pend_valid;
    logic              r_pend_is_exc;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_sel_valid;
    logic              w_sel_is_exc;
    logic [ADDR_W-1:0] w_sel_addr;

    // A new exception always replaces the entry; a new branch only fills an empty one.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_is_exc = 1'b0;
        w_sel_addr   = '0;
        if (i_exc_req) begin
            w_sel_valid  = 1'b1;
            w_sel_is_exc = 1'b1;
            w_sel_addr   = i_exc_vec;
        end else if (r_pend_valid) begin
            w_sel_valid  = 1'b1;
            w_sel_is_exc = r_pend_is_exc;
            w_sel_addr   = r_pend_addr;
        end else if (i_br_req) begin
            w_sel_valid  = 1'b1;
            w_sel_is_exc = 1'b0;
            w_sel_addr   = i_br_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_is_exc <= 1'b0;
            r_pend_addr   <= '0;
        end else if (i_consume) begin
            r_pend_valid  <= 1'b0;
            r_pend_is_exc <= 1'b0;
            r_pend_addr   <= '0;
        end else begin
            r_pend_valid  <= w_sel_valid;
            r_pend_is_exc <= w_sel_is_exc;
            r_pend_addr   <= w_sel_addr;
        end
    end

    assign o_sel_valid = w_sel_valid;
    assign o_sel_addr  = w_sel_addr;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage control sequencer: redirect arbitration, stall hold, flush bubbles, start/halt.
module fetch_seq_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall_in,
    input  logic              imem_ready,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_vec,
    output logic              enable_fetch,
    output logic              enable_updatePC,
    output logic              br_taken,
    output logic [ADDR_W-1:0] taddr,
    output logic              flush_out,
    output logic              busy,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    fetch_state_t      r_state, w_state_nxt;
    logic [2:0]        r_fcnt, w_fcnt_nxt;
    logic              r_en_fetch, w_en_fetch_nxt;
    logic              r_en_upd, w_en_upd_nxt;
    logic              r_br_taken, w_br_taken_nxt;
    logic [ADDR_W-1:0] r_taddr, w_taddr_nxt;
    logic              r_flush, w_flush_nxt;
    logic              r_busy, w_busy_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic              w_go;
    logic              w_consume;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_go = !stall_in && imem_ready;

    fetch_redirect_hold #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_br_req    (br_req),
        .i_br_addr   (br_addr),
        .i_exc_req   (exc_req),
        .i_exc_vec   (exc_vec),
        .i_consume   (w_consume),
        .o_sel_valid (w_sel_valid),
        .o_sel_addr  (w_sel_addr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_sel_valid && w_go) begin
                    w_state_nxt = REDIR;
                end else if (halt_req && w_go) begin
                    w_state_nxt = HALT;
                end
            end
            REDIR: begin
                if (FLUSH_CYCLES > 0) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FLUSH_LOAD;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                // A redirect still pending takes precedence over halting; it launches from RUN.
                if (r_fcnt == 3'd0) begin
                    if (halt_req && w_go && !w_sel_valid) w_state_nxt = HALT;
                    else                                   w_state_nxt = RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                end
            end
            HALT: begin
                if (start) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state after the edge.
    always_comb begin
        w_en_fetch_nxt = 1'b0;
        w_en_upd_nxt   = 1'b0;
        w_br_taken_nxt = 1'b0;
        w_flush_nxt    = 1'b0;
        w_taddr_nxt    = r_taddr;
        w_cnt_nxt      = r_cnt;
        w_consume      = 1'b0;
        w_busy_nxt     = (w_state_nxt == RUN) || (w_state_nxt == REDIR) || (w_state_nxt == FLUSH);
        case (w_state_nxt)
            RUN: begin
                w_en_fetch_nxt = w_go;
                w_en_upd_nxt   = w_go;
            end
            REDIR: begin
                w_en_upd_nxt   = 1'b1;
                w_br_taken_nxt = 1'b1;
                w_flush_nxt    = 1'b1;
                w_taddr_nxt    = w_sel_addr;
                w_consume      = 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fcnt     <= 3'd0;
            r_en_fetch <= 1'b0;
            r_en_upd   <= 1'b0;
            r_br_taken <= 1'b0;
            r_taddr    <= '0;
            r_flush    <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_en_fetch <= w_en_fetch_nxt;
            r_en_upd   <= w_en_upd_nxt;
            r_br_taken <= w_br_taken_nxt;
            r_taddr    <= w_taddr_nxt;
            r_flush    <= w_flush_nxt;
            r_busy     <= w_busy_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign enable_fetch    = r_en_fetch;
    assign enable_updatePC = r_en_upd;
    assign br_taken        = r_br_taken;
    assign taddr           = r_taddr;
    assign flush_out       = r_flush;
    assign busy            = r_busy;
    assign redirect_cnt    = r_cnt;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed sequences plus a redirect-address scoreboard.
module tb_fetch_seq_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        stall_in;
    logic        imem_ready;
    logic        br_req;
    logic [15:0] br_addr;
    logic        exc_req;
    logic [15:0] exc_vec;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        br_taken;
    logic [15:0] taddr;
    logic        flush_out;
    logic        busy;
    logic [7:0]  redirect_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    redirect_t   exp_q[$];
    redirect_t   mon_e;

    fetch_seq_ctrl #(
        .ADDR_W       (16),
        .FLUSH_CYCLES (2),
        .CNT_W        (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .halt_req        (halt_req),
        .stall_in        (stall_in),
        .imem_ready      (imem_ready),
        .br_req          (br_req),
        .br_addr         (br_addr),
        .exc_req         (exc_req),
        .exc_vec         (exc_vec),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .flush_out       (flush_out),
        .busy            (busy),
        .redirect_cnt    (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redir(input logic is_exc, input logic [15:0] a);
        exp_q.push_back({1'b1, is_exc, a});
    endtask

    // Every issued redirect must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && br_taken) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_redir", {31'd0, br_taken}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("redir_taddr", {16'd0, taddr}, {16'd0, mon_e.addr});
                check_eq("redir_flush", {31'd0, flush_out}, 32'd1);
                check_eq("redir_no_fetch", {31'd0, enable_fetch}, 32'd0);
            end
        end
    end

    task automatic do_redirect(input logic [15:0] a);
        br_req  = 1'b1;
        br_addr = a;
        expect_redir(1'b0, a);
        step();
        br_req = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt_req = 1'b0; stall_in = 1'b0; imem_ready = 1'b1;
        br_req = 1'b0; br_addr = '0; exc_req = 1'b0; exc_vec = '0;
        step();
        step();
        check_eq("rst_en_fetch", {31'd0, enable_fetch}, 32'd0);
        check_eq("rst_en_upd", {31'd0, enable_updatePC}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_taddr", {16'd0, taddr}, 32'd0);
        check_eq("rst_cnt", {24'd0, redirect_cnt}, 32'd0);
        reset = 1'b1;

        // Start
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t1_en_fetch", {31'd0, enable_fetch}, 32'd1);
        check_eq("t1_en_upd", {31'd0, enable_updatePC}, 32'd1);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        check_eq("t1_br_taken", {31'd0, br_taken}, 32'd0);
        check_eq("t1_taddr", {16'd0, taddr}, 32'd0);

        // Plain branch, then two bubbles
        br_req = 1'b1; br_addr = 16'h3050; expect_redir(1'b0, 16'h3050);
        step();
        br_req = 1'b0;
        check_eq("t2_br_taken", {31'd0, br_taken}, 32'd1);
        check_eq("t2_en_upd", {31'd0, enable_updatePC}, 32'd1);
        check_eq("t2_cnt", {24'd0, redirect_cnt}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("t2_flush_fetch", {31'd0, enable_fetch}, 32'd0);
            check_eq("t2_flush_upd", {31'd0, enable_updatePC}, 32'd0);
            check_eq("t2_flush_busy", {31'd0, busy}, 32'd1);
        end
        step();
        check_eq("t2_run_fetch", {31'd0, enable_fetch}, 32'd1);
        check_eq("t2_taddr_hold", {16'd0, taddr}, 32'h3050);

        // Same-cycle exception and branch; then a branch arriving during FLUSH
        exc_req = 1'b1; exc_vec = 16'h0180; br_req = 1'b1; br_addr = 16'h3050;
        expect_redir(1'b1, 16'h0180);
        step();
        exc_req = 1'b0; br_req = 1'b0;
        check_eq("t3_taddr", {16'd0, taddr}, 32'h0180);
        check_eq("t3_cnt", {24'd0, redirect_cnt}, 32'd2);
        step();
        br_req = 1'b1; br_addr = 16'h5000; expect_redir(1'b0, 16'h5000);
        step();
        br_req = 1'b0;
        step();
        check_eq("t3_run_before_redir", {31'd0, enable_fetch}, 32'd1);
        check_eq("t3_no_early_redir", {31'd0, br_taken}, 32'd0);
        step();
        check_eq("t3_pend_taddr", {16'd0, taddr}, 32'h5000);
        check_eq("t3_pend_cnt", {24'd0, redirect_cnt}, 32'd3);
        step(); step(); step();

        // Stall holds the redirect; later exception overwrites the pending branch
        stall_in = 1'b1;
        br_req = 1'b1; br_addr = 16'h4000;
        step();
        br_req = 1'b0;
        check_eq("t4_stall_fetch", {31'd0, enable_fetch}, 32'd0);
        exc_req = 1'b1; exc_vec = 16'h0200; expect_redir(1'b1, 16'h0200);
        step();
        exc_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t4_stall_no_redir", {31'd0, br_taken}, 32'd0);
        end
        stall_in = 1'b0;
        step();
        check_eq("t4_taddr", {16'd0, taddr}, 32'h0200);
        check_eq("t4_cnt", {24'd0, redirect_cnt}, 32'd4);
        step(); step(); step();
        check_eq("t4_back_run", {31'd0, enable_fetch}, 32'd1);

        // Halt together with a branch: redirect first, then HALT
        halt_req = 1'b1; br_req = 1'b1; br_addr = 16'h3100; expect_redir(1'b0, 16'h3100);
        step();
        br_req = 1'b0;
        check_eq("t5_taddr", {16'd0, taddr}, 32'h3100);
        step(); step();
        check_eq("t5_flush_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("t5_halt_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_halt_fetch", {31'd0, enable_fetch}, 32'd0);
        halt_req = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t5_restart_busy", {31'd0, busy}, 32'd1);
        check_eq("t5_restart_fetch", {31'd0, enable_fetch}, 32'd1);

        // Asynchronous reset in the middle of FLUSH drops a pending redirect
        br_req = 1'b1; br_addr = 16'h6000; expect_redir(1'b0, 16'h6000);
        step();
        br_req = 1'b0;
        step();
        br_req = 1'b1; br_addr = 16'h7000;
        step();
        br_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("t6_async_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_async_taddr", {16'd0, taddr}, 32'd0);
        check_eq("t6_async_cnt", {24'd0, redirect_cnt}, 32'd0);
        check_eq("t6_async_upd", {31'd0, enable_updatePC}, 32'd0);
        step();
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t6_after_rst_fetch", {31'd0, enable_fetch}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t6_pending_lost", {31'd0, br_taken}, 32'd0);
        end

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            do_redirect(16'h8000 + 16'(i));
            if (i == 253) check_eq("t6_cnt_254", {24'd0, redirect_cnt}, 32'd254);
            if (i == 254) check_eq("t6_cnt_255", {24'd0, redirect_cnt}, 32'd255);
        end
        check_eq("t6_cnt_sat", {24'd0, redirect_cnt}, 32'hFF);
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
